// File: rtl/gf2_basis_builder_p.sv
// gf2_basis_builder_p: streaming GF(2) basis builder that keeps its rows in
// reduced-row-echelon form.
// Each accepted W-bit vector is reduced in one cycle. If it is independent it is
// appended, and every existing row is back-substituted so the form is kept.
// Optional feature macro: GF2_TRACK_INVERSE_EN. When it is defined, the block also
// keeps a transform matrix T (each basis row written as an XOR of accepted inputs),
// and the readout streams the B rows followed by the T rows.

// Per-row slice: pivot match against the incoming vector and back-substitution.
module gf2_bb_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] row,
  input  logic [W-1:0] in_vec,
  input  logic [W-1:0] red,
  input  logic [W-1:0] q_oh,
  output logic         match,
  output logic [W-1:0] row_nxt
);
  // One-hot of the most significant set bit (the row pivot).
  function automatic logic [W-1:0] msb_oh(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      if (v[b] && !found) begin
        r[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic hit;

  // An empty row has no pivot, so it never matches.
  assign match   = |(msb_oh(row) & in_vec);
  // This row holds the new pivot column and must have it cleared.
  assign hit     = |(row & q_oh);
  assign row_nxt = hit ? (row ^ red) : row;
endmodule

module gf2_basis_builder_p #(
  parameter int W      = 32,
  parameter int RANK_W = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_vec,
  output logic              res_valid,
  output logic              res_indep,
  output logic [RANK_W-1:0] res_index,
  output logic [RANK_W-1:0] rank,
  output logic              full,
  input  logic              rd_start,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [W-1:0]      rd_data,
  output logic              rd_last
);

`ifdef GF2_TRACK_INVERSE_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef enum logic [1:0] {BUILD, READ_B, READ_T} state_t;

  state_t                  state;
  logic [W-1:0][W-1:0]     row_q;
  logic [W-1:0][W-1:0]     row_nxt;
  logic [W-1:0]            match;
  logic [W-1:0]            red;
  logic [W-1:0]            q_oh;
  logic                    indep;
  logic                    hs;
  logic [RANK_W-1:0]       rd_idx;
  logic [RANK_W-1:0]       rd_idx_inc;

  function automatic logic [W-1:0] msb_oh(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      if (v[b] && !found) begin
        r[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Select row idx of a matrix without an out-of-range dynamic index.
  function automatic logic [W-1:0] pick(input logic [W-1:0][W-1:0] a,
                                        input logic [RANK_W-1:0]   idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (RANK_W'(i) == idx) r = a[i];
    end
    return r;
  endfunction

  assign hs         = in_valid & in_ready & clk_en;
  assign full       = (rank == RANK_W'(W));
  assign rd_idx_inc = rd_idx + RANK_W'(1);

  for (genvar g = 0; g < W; g++) begin : g_row
    gf2_bb_row #(.W(W)) u_row (
      .row     (row_q[g]),
      .in_vec  (in_vec),
      .red     (red),
      .q_oh    (q_oh),
      .match   (match[g]),
      .row_nxt (row_nxt[g])
    );
  end

  // Reduce the candidate: XOR in every row whose pivot bit the candidate has set.
  always_comb begin
    red = in_vec;
    for (int i = 0; i < W; i++) begin
      if (match[i]) red = red ^ row_q[i];
    end
  end

  assign q_oh  = msb_oh(red);
  assign indep = |red;

`ifdef GF2_TRACK_INVERSE_EN
  // Identity seeded so that T row i starts as the unit vector for input slot i.
  function automatic logic [W-1:0][W-1:0] t_identity();
    logic [W-1:0][W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i]            = '0;
      r[i][W - 1 - i] = 1'b1;
    end
    return r;
  endfunction

  localparam logic [W-1:0][W-1:0] T_INIT = t_identity();

  logic [W-1:0][W-1:0] t_q;
  logic [W-1:0]        tsel;
  logic [W-1:0]        t_base;
  logic [W-1:0]        t_new;

  // Transform row of the new basis row: seed row at slot rank, XORed with the T rows that matched.
  always_comb begin
    tsel   = '0;
    t_base = '0;
    for (int i = 0; i < W; i++) begin
      if (match[i]) tsel = tsel ^ t_q[i];
      if (RANK_W'(i) == rank) t_base = t_q[i];
    end
    t_new = t_base ^ tsel;
  end

  // T storage follows the same append and back-substitution as the basis rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q <= T_INIT;
    end else if (clear) begin
      t_q <= T_INIT;
    end else if (clk_en && hs && indep) begin
      for (int i = 0; i < W; i++) begin
        if (RANK_W'(i) == rank)      t_q[i] <= t_new;
        else if (|(row_q[i] & q_oh)) t_q[i] <= t_q[i] ^ t_new;
      end
    end
  end
`endif

  // Basis update, per-vector result and readout FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BUILD;
      row_q     <= '0;
      rank      <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_indep <= 1'b0;
      res_index <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      rd_idx    <= '0;
    end else if (clear) begin
      state     <= BUILD;
      row_q     <= '0;
      rank      <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_indep <= 1'b0;
      res_index <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      rd_idx    <= '0;
    end else if (clk_en) begin
      res_valid <= hs;
      res_indep <= hs & indep;
      res_index <= (hs && indep) ? rank : '0;
      // A full basis always reduces to zero, so rank cannot pass W.
      if (hs && indep) begin
        for (int i = 0; i < W; i++) begin
          row_q[i] <= (RANK_W'(i) == rank) ? red : row_nxt[i];
        end
        rank <= rank + RANK_W'(1);
      end
      case (state)
        BUILD: begin
          // An input handshake in the same cycle takes priority over rd_start.
          if (rd_start && !hs) begin
            state    <= READ_B;
            in_ready <= 1'b0;
            rd_valid <= 1'b1;
            rd_idx   <= '0;
            rd_data  <= row_q[0];
            rd_last  <= TRACK ? (rank == '0) : (rank < RANK_W'(2));
          end
        end
        READ_B: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              state    <= BUILD;
              in_ready <= 1'b1;
              rd_valid <= 1'b0;
              rd_data  <= '0;
              rd_last  <= 1'b0;
              rd_idx   <= '0;
            end else if (rd_idx_inc < rank) begin
              rd_idx  <= rd_idx_inc;
              rd_data <= pick(row_q, rd_idx_inc);
              rd_last <= !TRACK && ((rd_idx_inc + RANK_W'(1)) == rank);
            end
`ifdef GF2_TRACK_INVERSE_EN
            else begin
              state   <= READ_T;
              rd_idx  <= '0;
              rd_data <= t_q[0];
              rd_last <= (rank == RANK_W'(1));
            end
`endif
          end
        end
`ifdef GF2_TRACK_INVERSE_EN
        READ_T: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              state    <= BUILD;
              in_ready <= 1'b1;
              rd_valid <= 1'b0;
              rd_data  <= '0;
              rd_last  <= 1'b0;
              rd_idx   <= '0;
            end else begin
              rd_idx  <= rd_idx_inc;
              rd_data <= pick(t_q, rd_idx_inc);
              rd_last <= ((rd_idx_inc + RANK_W'(1)) == rank);
            end
          end
        end
`endif
        default: begin
          state    <= BUILD;
          in_ready <= 1'b1;
          rd_valid <= 1'b0;
          rd_data  <= '0;
          rd_last  <= 1'b0;
          rd_idx   <= '0;
        end
      endcase
    end
  end

endmodule
